engine_run_ctrl: RTL and testbench

Run controller for one test-engine pass: turns a software start command into the `engine_start_pulse` consumed by the AXI read and write masters. It waits for their `rd_done_pulse`/`wr_done_pulse`, accumulates their error codes and measures elapsed cycles. It enforces an optional timeout and raises a held interrupt request until acknowledged. It sits between the MMIO register block (upstream) and the read/write master pair (downstream).

---
 rtl/engine_run_ctrl_if.sv | 25 ++
 rtl/engine_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_engine_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/engine_run_ctrl_if.sv
// Launch/completion handshake between the run controller and the AXI read/write master pair.
// The controller drives the launch pulse; the masters return done pulses and error codes.
interface engine_run_ctrl_if;
  logic       engine_start_pulse;
  logic       rd_done_pulse;
  logic       wr_done_pulse;
  logic [1:0] rd_error;
  logic [1:0] wr_error;

  modport master (
    output engine_start_pulse,
    input  rd_done_pulse,
    input  wr_done_pulse,
    input  rd_error,
    input  wr_error
  );

  modport slave (
    input  engine_start_pulse,
    output rd_done_pulse,
    output wr_done_pulse,
    output rd_error,
    output wr_error
  );
endinterface

// File: rtl/engine_run_ctrl.sv
// Run controller for one test-engine pass: launches the read/write masters, waits for their
// completion, accumulates errors, times the run against an optional limit and raises an IRQ.
module engine_run_ctrl #(
  parameter int unsigned TIMER_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   rd_enable,
  input  logic                   wr_enable,
  input  logic                   int_enable,
  input  logic [TIMER_WIDTH-1:0] timeout_cycles,
  engine_run_ctrl_if.master      eng,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [TIMER_WIDTH-1:0] elapsed_cycles,
  output logic [7:0]             status,
  output logic                   int_req,
  input  logic                   int_ack
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StFinish,
    StIntWait
  } state_e;

  state_e                 state_q;
  logic                   rd_en_q;
  logic                   wr_en_q;
  logic                   start_pulse_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   int_req_q;
  logic [TIMER_WIDTH-1:0] elapsed_q;
  // {start_overrun, timeout, wr_err[1:0], rd_err[1:0], wr_seen, rd_seen}
  logic [7:0]             status_q;

  logic [1:0]             rd_hit;
  logic [1:0]             wr_hit;
  logic                   rd_seen_d;
  logic                   wr_seen_d;
  logic [1:0]             rd_err_d;
  logic [1:0]             wr_err_d;
  logic                   run_complete;
  logic                   timeout_hit;
  logic [TIMER_WIDTH-1:0] elapsed_inc;

  always_comb begin
    rd_hit = eng.rd_done_pulse ? eng.rd_error : 2'b00;
    wr_hit = eng.wr_done_pulse ? eng.wr_error : 2'b00;
    // While running, any reported error is sticky even without a done pulse.
    if (state_q == StRun) begin
      rd_hit = eng.rd_error;
      wr_hit = eng.wr_error;
    end
    rd_seen_d    = status_q[0] | eng.rd_done_pulse;
    wr_seen_d    = status_q[1] | eng.wr_done_pulse;
    rd_err_d     = status_q[3:2] | rd_hit;
    wr_err_d     = status_q[5:4] | wr_hit;
    run_complete = (rd_seen_d | ~rd_en_q) & (wr_seen_d | ~wr_en_q);
    timeout_hit  = (timeout_cycles != '0) &&
                   (elapsed_q == timeout_cycles - TIMER_WIDTH'(1));
    elapsed_inc  = (&elapsed_q) ? elapsed_q : elapsed_q + TIMER_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      int_req_q     <= 1'b0;
      elapsed_q     <= '0;
      status_q      <= '0;
    end else begin
      start_pulse_q <= 1'b0;
      done_q        <= 1'b0;
      if (i_start && (state_q != StIdle)) begin
        status_q[7] <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            rd_en_q   <= rd_enable;
            wr_en_q   <= wr_enable;
            status_q  <= '0;
            elapsed_q <= '0;
            busy_q    <= 1'b1;
            if (rd_enable || wr_enable) begin
              state_q       <= StLaunch;
              start_pulse_q <= 1'b1;
            end else begin
              // Nothing to wait for: report an empty run straight away.
              state_q <= StFinish;
              done_q  <= 1'b1;
            end
          end
        end
        StLaunch: begin
          status_q[5:0] <= {wr_err_d, rd_err_d, wr_seen_d, rd_seen_d};
          state_q       <= StRun;
        end
        StRun: begin
          status_q[5:0] <= {wr_err_d, rd_err_d, wr_seen_d, rd_seen_d};
          elapsed_q     <= elapsed_inc;
          // Completion takes priority over a timeout landing on the same edge.
          if (run_complete) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            status_q[6] <= 1'b1;
            state_q     <= StFinish;
            done_q      <= 1'b1;
          end
        end
        StFinish: begin
          if (int_enable) begin
            state_q   <= StIntWait;
            int_req_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIntWait: begin
          if (int_ack) begin
            state_q   <= StIdle;
            int_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng.engine_start_pulse = start_pulse_q;
  assign busy                   = busy_q;
  assign done_pulse             = done_q;
  assign elapsed_cycles         = elapsed_q;
  assign status                 = status_q;
  assign int_req                = int_req_q;

endmodule

// File: tb/tb_engine_run_ctrl.sv
// Scoreboard bench for engine_run_ctrl: a driver issues randomized runs and queues the
// expected outcome; a monitor pops and compares whenever the DUT reports end of run.
module tb_engine_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        rd_enable;
  logic        wr_enable;
  logic        int_enable;
  logic [63:0] timeout_cycles;
  logic        busy;
  logic        done_pulse;
  logic [63:0] elapsed_cycles;
  logic [7:0]  status;
  logic        int_req;
  logic        int_ack;

  engine_run_ctrl_if bus ();

  engine_run_ctrl #(
    .TIMER_WIDTH(64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .rd_enable      (rd_enable),
    .wr_enable      (wr_enable),
    .int_enable     (int_enable),
    .timeout_cycles (timeout_cycles),
    .eng            (bus.master),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .elapsed_cycles (elapsed_cycles),
    .status         (status),
    .int_req        (int_req),
    .int_ack        (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          start_edge;
    int          latency;
    logic [63:0] elapsed;
    logic [7:0]  st_done;
    logic [7:0]  st_idle;
    bit          int_en;
    bit          any_en;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares against the queued expectation at done, just after, and when idle.
  exp_t cur;
  bit   have_last = 1'b0;
  bit   int_chk   = 1'b0;
  bit   prev_busy = 1'b0;
  bit   prev_int  = 1'b0;
  int   starts    = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_last = 1'b0;
        int_chk   = 1'b0;
        prev_busy = 1'b0;
        prev_int  = 1'b0;
        starts    = 0;
      end else begin
        if (int_chk) begin
          check("int_req_after_done", int_req, cur.int_en);
          int_chk = 1'b0;
        end
        if (bus.engine_start_pulse) starts++;
        if (done_pulse) begin
          if (sb.size() == 0) begin
            check("done_without_run", 1'b1, 1'b0);
          end else begin
            cur = sb.pop_front();
            have_last = 1'b1;
            check("done_latency", cyc - cur.start_edge, cur.latency);
            check("status_at_done", status, cur.st_done);
            check("elapsed_at_done", elapsed_cycles, cur.elapsed);
            check("busy_at_done", busy, 1'b1);
            check("int_req_at_done", int_req, 1'b0);
            check("launch_count", starts, cur.any_en ? 1 : 0);
            starts  = 0;
            int_chk = 1'b1;
          end
        end
        if (prev_busy && !busy && have_last) begin
          check("status_idle", status, cur.st_idle);
          check("elapsed_idle", elapsed_cycles, cur.elapsed);
          check("int_req_idle", int_req, 1'b0);
          check("int_req_held_to_ack", prev_int, cur.int_en);
        end
        if (i_start && !busy && have_last) begin
          check("status_before_start", status, cur.st_idle);
          check("elapsed_before_start", elapsed_cycles, cur.elapsed);
          have_last = 1'b0;
        end
        prev_busy = busy;
        prev_int  = int_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a master pulse d cycles after launch counts at RUN edge max(d,1)-1; elapsed
  // after RUN edge k is k+1; a limit T ends the run at RUN edge T-1 unless completion ties.
  task automatic run_one(input bit rd_en, input bit wr_en, input bit int_en, input int d_rd,
                         input int d_wr, input logic [1:0] e_rd, input logic [1:0] e_wr,
                         input int tmo, input bit stray, input bit stray_int,
                         input int ack_wait);
    exp_t e;
    int   k_rd, k_wr, k_c, k_end, maxd, n;
    bit   to, rs, ws, si;
    si   = stray_int && int_en;
    k_rd = (d_rd < 1) ? 0 : d_rd - 1;
    k_wr = (d_wr < 1) ? 0 : d_wr - 1;
    k_c  = 0;
    if (rd_en && k_rd > k_c) k_c = k_rd;
    if (wr_en && k_wr > k_c) k_c = k_wr;
    to    = (tmo != 0) && (tmo - 1 < k_c);
    k_end = to ? tmo - 1 : k_c;
    rs    = rd_en && (k_rd <= k_end);
    ws    = wr_en && (k_wr <= k_end);
    e.any_en = rd_en || wr_en;
    e.int_en = int_en;
    if (e.any_en) begin
      e.latency = 2 + k_end;
      e.elapsed = 64'(k_end + 1);
      e.st_done = {stray, to, ws ? e_wr : 2'b00, rs ? e_rd : 2'b00, ws, rs};
    end else begin
      e.latency = 0;
      e.elapsed = 64'd0;
      e.st_done = 8'h00;
    end
    e.st_idle = e.st_done | {(stray || si), 7'b0};

    rd_enable      = rd_en;
    wr_enable      = wr_en;
    int_enable     = int_en;
    timeout_cycles = 64'(tmo);
    i_start        = 1'b1;
    e.start_edge   = cyc + 1;
    sb.push_back(e);

    maxd = 0;
    if (rd_en && d_rd > maxd) maxd = d_rd;
    if (wr_en && d_wr > maxd) maxd = d_wr;
    for (int j = 0; j <= maxd; j++) begin
      tick();
      i_start           = (j == 0) && stray;
      int_ack           = (j == 1) && stray;
      bus.rd_done_pulse = rd_en && (d_rd == j);
      bus.rd_error      = bus.rd_done_pulse ? e_rd : 2'b00;
      bus.wr_done_pulse = wr_en && (d_wr == j);
      bus.wr_error      = bus.wr_done_pulse ? e_wr : 2'b00;
    end
    tick();
    i_start           = 1'b0;
    int_ack           = 1'b0;
    bus.rd_done_pulse = 1'b0;
    bus.wr_done_pulse = 1'b0;
    bus.rd_error      = 2'b00;
    bus.wr_error      = 2'b00;

    if (int_en) begin
      n = 0;
      while (!int_req && n < 400) begin
        tick();
        n++;
      end
      check("int_req_raised", int_req, 1'b1);
      if (int_req) begin
        if (si) begin
          i_start = 1'b1;
          tick();
          i_start = 1'b0;
        end
        repeat (ack_wait) tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
      end
    end
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("busy_released", busy, 1'b0);
    repeat (2) tick();
  endtask

  task automatic reset_midrun();
    rd_enable      = 1'b1;
    wr_enable      = 1'b1;
    int_enable     = 1'b1;
    timeout_cycles = 64'd0;
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (12) tick();
    check("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_pulse, 1'b0);
    check("rst_int_req", int_req, 1'b0);
    check("rst_start_pulse", bus.engine_start_pulse, 1'b0);
    check("rst_status", status, 8'h00);
    check("rst_elapsed", elapsed_cycles, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    i_start           = 1'b0;
    rd_enable         = 1'b0;
    wr_enable         = 1'b0;
    int_enable        = 1'b0;
    timeout_cycles    = 64'd0;
    int_ack           = 1'b0;
    bus.rd_done_pulse = 1'b0;
    bus.wr_done_pulse = 1'b0;
    bus.rd_error      = 2'b00;
    bus.wr_error      = 2'b00;
    repeat (2) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done_pulse, 1'b0);
    check("reset_int_req", int_req, 1'b0);
    check("reset_start_pulse", bus.engine_start_pulse, 1'b0);
    check("reset_status", status, 8'h00);
    check("reset_elapsed", elapsed_cycles, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_one(1, 0, 0, 100, 0, 2'b00, 2'b00, 0, 0, 0, 1);   // read only
    run_one(1, 1, 0, 5, 5, 2'b10, 2'b00, 0, 0, 0, 1);     // both, same cycle
    run_one(1, 0, 0, 70, 0, 2'b01, 2'b00, 50, 0, 0, 1);   // timeout, late master
    run_one(1, 0, 0, 20, 0, 2'b00, 2'b00, 20, 0, 0, 1);   // timeout/done tie
    run_one(1, 1, 1, 3, 4, 2'b00, 2'b11, 0, 0, 1, 20);    // interrupt, start during wait
    run_one(0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 3);     // no master enabled
    run_one(1, 1, 0, 0, 1, 2'b01, 2'b10, 0, 1, 0, 1);     // minimum length, overrun
    run_one(1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1);     // limit of 1 ties at first edge

    for (int r = 0; r < 40; r++) begin
      int  mode, tmo;
      bit  ren, wen, ien;
      mode = int'($urandom_range(0, 9));
      ren  = (mode != 0) && (mode != 1);
      wen  = (mode != 0) && (mode != 2);
      ien  = $urandom_range(0, 1) == 1;
      tmo  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
      run_one(ren, wen, ien, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), tmo,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              int'($urandom_range(1, 20)));
    end

    reset_midrun();
    run_one(1, 0, 0, 10, 0, 2'b00, 2'b00, 0, 0, 0, 1);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
